// File: rtl/bp_common_pkg.sv
// Shared BedRock definitions: processor configs, LCE request/command headers and mux limits.
// Consumers of these headers: bp_lce_mux (optional stats via BP_LCE_MUX_STATS_EN).
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg      = 2'd0,
    e_bp_unicore_half_cfg = 2'd1
  } bp_params_e;

  localparam int lce_id_width_gp    = 4;
  localparam int paddr_width_gp     = 40;
  localparam int lce_mux_max_lce_gp = 8;

  typedef enum logic [3:0] {
    e_bedrock_req_rd_miss = 4'd0,
    e_bedrock_req_wr_miss = 4'd1,
    e_bedrock_req_uc_rd   = 4'd2,
    e_bedrock_req_uc_wr   = 4'd3
  } bp_bedrock_req_type_e;

  typedef enum logic [3:0] {
    e_bedrock_cmd_sync      = 4'd0,
    e_bedrock_cmd_set_clear = 4'd1,
    e_bedrock_cmd_inv       = 4'd2,
    e_bedrock_cmd_st        = 4'd3,
    e_bedrock_cmd_data      = 4'd4
  } bp_bedrock_cmd_type_e;

  typedef enum logic [2:0] {
    e_coh_i = 3'd0,
    e_coh_s = 3'd1,
    e_coh_e = 3'd2,
    e_coh_m = 3'd3
  } bp_coh_states_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] src_id;
    logic [2:0]                 lru_way_id;
  } bp_bedrock_lce_req_payload_s;

  typedef struct packed {
    bp_bedrock_req_type_e        msg_type;
    logic [2:0]                  size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_lce_req_payload_s payload;
  } bp_bedrock_lce_req_header_s;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] dst_id;
    logic [2:0]                 way_id;
    bp_coh_states_e             state;
  } bp_bedrock_lce_cmd_payload_s;

  typedef struct packed {
    bp_bedrock_cmd_type_e        msg_type;
    logic [2:0]                  size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_lce_cmd_payload_s payload;
  } bp_bedrock_lce_cmd_header_s;

  localparam int lce_req_header_width_gp = $bits(bp_bedrock_lce_req_header_s);
  localparam int lce_cmd_header_width_gp = $bits(bp_bedrock_lce_cmd_header_s);

  function automatic int proc_cce_block_width(bp_params_e cfg);
    case (cfg)
      e_bp_unicore_half_cfg: return 32;
      default:               return 64;
    endcase
  endfunction

endpackage

// File: rtl/bp_lce_mux_rr_arb.sv
// Round-robin arbiter: priority starts at rr_q and wraps; rr_q advances past the
// winner only when the grant is actually consumed (yumi_i).
module bp_lce_mux_rr_arb
  import bp_common_pkg::*;
#(
  parameter int num_lce_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_lce_p-1:0] v_i,
  input  logic                 yumi_i,
  output logic [num_lce_p-1:0] grant_o
);

  localparam int rr_w_lp  = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
  localparam int sum_w_lp = rr_w_lp + 1;

  logic [rr_w_lp-1:0]  rr_q, rr_d;
  logic [rr_w_lp-1:0]  gnt_idx;
  logic [sum_w_lp-1:0] idx_sum;
  logic                found;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    grant_o = '0;
    gnt_idx = '0;
    idx_sum = '0;
    found   = 1'b0;
    for (int k = 0; k < num_lce_p; k++) begin
      idx_sum = {1'b0, rr_q} + sum_w_lp'(k);
      if (idx_sum >= sum_w_lp'(num_lce_p)) begin
        idx_sum = idx_sum - sum_w_lp'(num_lce_p);
      end
      if (!found && v_i[idx_sum[rr_w_lp-1:0]]) begin
        grant_o[idx_sum[rr_w_lp-1:0]] = 1'b1;
        gnt_idx                       = idx_sum[rr_w_lp-1:0];
        found                         = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (yumi_i) begin
      rr_d = (gnt_idx == rr_w_lp'(num_lce_p - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/bp_lce_mux.sv
// N-way LCE concentrator: round-robin merge of requests into one output register,
// destination-ID routing of commands. Optional per-channel counters: BP_LCE_MUX_STATS_EN.
// Instantiation note: lce_req_ready_and_o depends combinationally on lce_req_v_i.
module bp_lce_mux
  import bp_common_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int num_lce_p = 2,
  localparam int lce_id_width_p          = lce_id_width_gp,
  localparam int cce_block_width_p       = proc_cce_block_width(bp_params_p),
  localparam int lce_req_header_width_lp = lce_req_header_width_gp,
  localparam int lce_cmd_header_width_lp = lce_cmd_header_width_gp
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic [lce_id_width_p-1:0]                         lce_id_base_i,

  input  logic [num_lce_p-1:0][lce_req_header_width_lp-1:0] lce_req_header_i,
  input  logic [num_lce_p-1:0][cce_block_width_p-1:0]       lce_req_data_i,
  input  logic [num_lce_p-1:0]                              lce_req_v_i,
  output logic [num_lce_p-1:0]                              lce_req_ready_and_o,

  output logic [lce_req_header_width_lp-1:0]                lce_req_header_o,
  output logic [cce_block_width_p-1:0]                      lce_req_data_o,
  output logic                                              lce_req_v_o,
  input  logic                                              lce_req_ready_and_i,

  input  logic [lce_cmd_header_width_lp-1:0]                lce_cmd_header_i,
  input  logic [cce_block_width_p-1:0]                      lce_cmd_data_i,
  input  logic                                              lce_cmd_v_i,
  output logic                                              lce_cmd_yumi_o,

  output logic [num_lce_p-1:0][lce_cmd_header_width_lp-1:0] lce_cmd_header_o,
  output logic [num_lce_p-1:0][cce_block_width_p-1:0]       lce_cmd_data_o,
  output logic [num_lce_p-1:0]                              lce_cmd_v_o,
  input  logic [num_lce_p-1:0]                              lce_cmd_yumi_i,

  output logic                                              cmd_misroute_o,
  output logic [num_lce_p-1:0][31:0]                        req_count_o
);

  localparam logic [lce_id_width_p:0] num_lce_lp = (lce_id_width_p + 1)'(num_lce_p);

  // ---------------- request path ----------------
  logic [num_lce_p-1:0]               grant;
  logic                               space;
  logic                               load;
  logic [lce_req_header_width_lp-1:0] sel_hdr;
  logic [cce_block_width_p-1:0]       sel_data;

  logic                               out_v_q, out_v_d;
  logic [lce_req_header_width_lp-1:0] out_hdr_q, out_hdr_d;
  logic [cce_block_width_p-1:0]       out_data_q, out_data_d;

  bp_lce_mux_rr_arb #(
    .num_lce_p (num_lce_p)
  ) u_rr_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (lce_req_v_i),
    .yumi_i  (load),
    .grant_o (grant)
  );

  assign space               = ~out_v_q | lce_req_ready_and_i;
  assign lce_req_ready_and_o = {num_lce_p{space}} & grant;
  assign load                = space & (|grant);

  always_comb begin
    sel_hdr  = '0;
    sel_data = '0;
    for (int j = 0; j < num_lce_p; j++) begin
      if (grant[j]) begin
        sel_hdr  = lce_req_header_i[j];
        sel_data = lce_req_data_i[j];
      end
    end
  end

  // A drain and a load in the same cycle leave the register full with the new entry.
  always_comb begin
    out_v_d    = out_v_q & ~lce_req_ready_and_i;
    out_hdr_d  = out_hdr_q;
    out_data_d = out_data_q;
    if (load) begin
      out_v_d    = 1'b1;
      out_hdr_d  = sel_hdr;
      out_data_d = sel_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_v_q <= 1'b0;
    end else begin
      out_v_q <= out_v_d;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while out_v_q
  // is set, which reset clears.
  always_ff @(posedge clk_i) begin
    out_hdr_q  <= out_hdr_d;
    out_data_q <= out_data_d;
  end

  assign lce_req_v_o      = out_v_q;
  assign lce_req_header_o = out_hdr_q;
  assign lce_req_data_o   = out_data_q;

  // ---------------- command path ----------------
  bp_bedrock_lce_cmd_header_s cmd_hdr;
  logic [lce_id_width_p-1:0]  cmd_idx;
  logic                       cmd_in_range;
  logic                       cmd_yumi_sel;
  logic                       cmd_drop;
  logic                       misroute_q, misroute_d;

  assign cmd_hdr      = bp_bedrock_lce_cmd_header_s'(lce_cmd_header_i);
  // Unsigned wrap: IDs below the base land far out of range and are dropped.
  assign cmd_idx      = cmd_hdr.payload.dst_id - lce_id_base_i;
  assign cmd_in_range = {1'b0, cmd_idx} < num_lce_lp;
  assign cmd_drop     = lce_cmd_v_i & ~cmd_in_range;

  always_comb begin
    lce_cmd_v_o  = '0;
    cmd_yumi_sel = 1'b0;
    for (int j = 0; j < num_lce_p; j++) begin
      lce_cmd_header_o[j] = cmd_hdr;
      lce_cmd_data_o[j]   = lce_cmd_data_i;
      if (cmd_idx == lce_id_width_p'(j)) begin
        lce_cmd_v_o[j] = lce_cmd_v_i;
        cmd_yumi_sel   = lce_cmd_yumi_i[j];
      end
    end
  end

  assign lce_cmd_yumi_o = cmd_in_range ? cmd_yumi_sel : lce_cmd_v_i;

  assign misroute_d = misroute_q | cmd_drop;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      misroute_q <= 1'b0;
    end else begin
      misroute_q <= misroute_d;
    end
  end

  // The drop cycle itself already reports the misroute.
  assign cmd_misroute_o = misroute_q | cmd_drop;

  // ---------------- statistics ----------------
`ifdef BP_LCE_MUX_STATS_EN
  logic [num_lce_p-1:0][31:0] cnt_q, cnt_d;

  always_comb begin
    for (int j = 0; j < num_lce_p; j++) begin
      cnt_d[j] = cnt_q[j] + {31'b0, lce_req_ready_and_o[j]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign req_count_o = cnt_q;
`else
  assign req_count_o = '0;
`endif

endmodule

// File: tb/tb_bp_lce_mux.sv
// Scoreboard bench for bp_lce_mux (N=3, base ID 4): request path via a reference
// model and queue, command routing via a directed table.
module tb_bp_lce_mux;
  import bp_common_pkg::*;

  localparam int N  = 3;
  localparam int IW = lce_id_width_gp;
  localparam int HW = lce_req_header_width_gp;
  localparam int CW = lce_cmd_header_width_gp;
  localparam int DW = proc_cce_block_width(e_bp_default_cfg);

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic [IW-1:0]        lce_id_base_i;
  logic [N-1:0][HW-1:0] lce_req_header_i;
  logic [N-1:0][DW-1:0] lce_req_data_i;
  logic [N-1:0]         lce_req_v_i;
  logic [N-1:0]         lce_req_ready_and_o;
  logic [HW-1:0]        lce_req_header_o;
  logic [DW-1:0]        lce_req_data_o;
  logic                 lce_req_v_o;
  logic                 lce_req_ready_and_i;
  logic [CW-1:0]        lce_cmd_header_i;
  logic [DW-1:0]        lce_cmd_data_i;
  logic                 lce_cmd_v_i;
  logic                 lce_cmd_yumi_o;
  logic [N-1:0][CW-1:0] lce_cmd_header_o;
  logic [N-1:0][DW-1:0] lce_cmd_data_o;
  logic [N-1:0]         lce_cmd_v_o;
  logic [N-1:0]         lce_cmd_yumi_i;
  logic                 cmd_misroute_o;
  logic [N-1:0][31:0]   req_count_o;

  always #5 clk_i = ~clk_i;

  bp_lce_mux #(
    .bp_params_p (e_bp_default_cfg),
    .num_lce_p   (N)
  ) u_dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .lce_id_base_i       (lce_id_base_i),
    .lce_req_header_i    (lce_req_header_i),
    .lce_req_data_i      (lce_req_data_i),
    .lce_req_v_i         (lce_req_v_i),
    .lce_req_ready_and_o (lce_req_ready_and_o),
    .lce_req_header_o    (lce_req_header_o),
    .lce_req_data_o      (lce_req_data_o),
    .lce_req_v_o         (lce_req_v_o),
    .lce_req_ready_and_i (lce_req_ready_and_i),
    .lce_cmd_header_i    (lce_cmd_header_i),
    .lce_cmd_data_i      (lce_cmd_data_i),
    .lce_cmd_v_i         (lce_cmd_v_i),
    .lce_cmd_yumi_o      (lce_cmd_yumi_o),
    .lce_cmd_header_o    (lce_cmd_header_o),
    .lce_cmd_data_o      (lce_cmd_data_o),
    .lce_cmd_v_o         (lce_cmd_v_o),
    .lce_cmd_yumi_i      (lce_cmd_yumi_i),
    .cmd_misroute_o      (cmd_misroute_o),
    .req_count_o         (req_count_o)
  );

  typedef struct packed {
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
  } req_t;

  req_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_rr;
  logic        m_out_v;
  logic [31:0] m_cnt [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_rr    = 0;
    m_out_v = 1'b0;
    for (int j = 0; j < N; j++) m_cnt[j] = '0;
  endtask

  // One clock of request traffic: drive, check at negedge, advance the model.
  task automatic req_cycle(input logic [N-1:0] v, input logic rdy, input logic rst);
    logic         space;
    logic [N-1:0] exp_rdy;
    logic [31:0]  exp_cnt;
    int           g;
    lce_req_v_i         = v;
    lce_req_ready_and_i = rdy;
    reset_i             = rst;
    for (int j = 0; j < N; j++) begin
      lce_req_header_i[j] = HW'({$urandom, $urandom});
      lce_req_data_i[j]   = {$urandom, $urandom};
    end
    @(negedge clk_i);
    space   = !m_out_v || rdy;
    g       = -1;
    exp_rdy = '0;
    for (int k = 0; k < N; k++) begin
      int j = (m_rr + k) % N;
      if (g < 0 && v[j]) g = j;
    end
    if (space && g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", lce_req_ready_and_o, exp_rdy);
    check("req_v_o", lce_req_v_o, m_out_v);
    for (int j = 0; j < N; j++) begin
`ifdef BP_LCE_MUX_STATS_EN
      exp_cnt = m_cnt[j];
`else
      exp_cnt = '0;
`endif
      check($sformatf("req_count%0d", j), req_count_o[j], exp_cnt);
    end
    if (m_out_v) begin
      if (sb_q.size() == 0) begin
        check("sb_depth", 64'(sb_q.size()), 64'd1);
      end else begin
        check("req_hdr_o", lce_req_header_o, sb_q[0].hdr);
        check("req_data_o", lce_req_data_o, sb_q[0].data);
        if (rdy) void'(sb_q.pop_front());
      end
    end
    if (rst) begin
      model_reset();
    end else if (space && g >= 0) begin
      sb_q.push_back('{hdr: lce_req_header_i[g], data: lce_req_data_i[g]});
      m_rr     = (g + 1) % N;
      m_out_v  = 1'b1;
      m_cnt[g] = m_cnt[g] + 32'd1;
    end else if (rdy) begin
      m_out_v = 1'b0;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Combinational command routing check, then one clock so the sticky flag updates.
  task automatic cmd_step(input int dst, input logic v, input logic [N-1:0] yumi,
                          input logic [N-1:0] exp_v, input logic exp_yumi, input logic exp_mis);
    bp_bedrock_lce_cmd_header_s h;
    h                = '0;
    h.msg_type       = e_bedrock_cmd_data;
    h.addr           = 40'($urandom);
    h.payload.dst_id = IW'(dst);
    h.payload.state  = e_coh_e;
    lce_cmd_header_i = h;
    lce_cmd_data_i   = {$urandom, $urandom};
    lce_cmd_v_i      = v;
    lce_cmd_yumi_i   = yumi;
    #2;
    check($sformatf("cmd_v_o dst%0d", dst), lce_cmd_v_o, exp_v);
    check($sformatf("cmd_yumi_o dst%0d", dst), lce_cmd_yumi_o, exp_yumi);
    check($sformatf("misroute dst%0d", dst), cmd_misroute_o, exp_mis);
    check("cmd_hdr_bcast", lce_cmd_header_o[N-1], h);
    check("cmd_data_bcast", lce_cmd_data_o[0], lce_cmd_data_i);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i             = 1'b1;
    lce_id_base_i       = IW'(4);
    lce_req_header_i    = '0;
    lce_req_data_i      = '0;
    lce_req_v_i         = '0;
    lce_req_ready_and_i = 1'b1;
    lce_cmd_header_i    = '0;
    lce_cmd_data_i      = '0;
    lce_cmd_v_i         = 1'b0;
    lce_cmd_yumi_i      = '0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    model_reset();
    #1;
    check("rst_req_v_o", lce_req_v_o, 1'b0);
    check("rst_ready", lce_req_ready_and_o, 3'b000);
    check("rst_misroute", cmd_misroute_o, 1'b0);
    for (int j = 0; j < N; j++) check($sformatf("rst_count%0d", j), req_count_o[j], 32'd0);

    //        dst  v     yumi_i  exp_v   yumi  mis
    cmd_step(4, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0);
    cmd_step(4, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0);
    cmd_step(4, 1'b1, 3'b110, 3'b001, 1'b0, 1'b0);
    cmd_step(6, 1'b1, 3'b100, 3'b100, 1'b1, 1'b0);
    cmd_step(6, 1'b1, 3'b011, 3'b100, 1'b0, 1'b0);
    cmd_step(5, 1'b1, 3'b010, 3'b010, 1'b1, 1'b0);
    cmd_step(5, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    cmd_step(9, 1'b1, 3'b000, 3'b000, 1'b1, 1'b1);
    cmd_step(5, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
    cmd_step(3, 1'b1, 3'b111, 3'b000, 1'b1, 1'b1);
    cmd_step(6, 1'b1, 3'b100, 3'b100, 1'b1, 1'b1);
    lce_cmd_v_i    = 1'b0;
    lce_cmd_yumi_i = '0;

    repeat (8) req_cycle(3'b011, 1'b1, 1'b0);
    repeat (6) req_cycle(3'b111, 1'b1, 1'b0);
    repeat (5) req_cycle(3'b111, 1'b0, 1'b0);
    req_cycle(3'b111, 1'b1, 1'b0);
    repeat (40) req_cycle(N'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);

    req_cycle(3'b001, 1'b1, 1'b0);
    req_cycle(3'b000, 1'b0, 1'b1);
    check("misroute_after_rst", cmd_misroute_o, 1'b0);
    lce_req_v_i         = 3'b111;
    lce_req_ready_and_i = 1'b1;
    #1;
    check("rr_after_rst", lce_req_ready_and_o, 3'b001);
    check("req_v_after_rst", lce_req_v_o, 1'b0);
    req_cycle(3'b111, 1'b1, 1'b0);

    req_cycle(3'b000, 1'b1, 1'b1);
    repeat (7) req_cycle(3'b010, 1'b1, 1'b0);
    req_cycle(3'b000, 1'b1, 1'b0);
`ifdef BP_LCE_MUX_STATS_EN
    check("stats_ch1", req_count_o[1], 32'd7);
`else
    check("stats_ch1", req_count_o[1], 32'd0);
`endif
    check("stats_ch0", req_count_o[0], 32'd0);
    check("stats_ch2", req_count_o[2], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_lce_mux.md
# bp_lce_mux

Parametrised N-way concentrator between a core's LCEs and a single coherence-network endpoint; the successor to the fixed two-LCE wiring in the core tile. Merges `num_lce_p` LCE request streams onto one registered outbound request port using round-robin arbitration. Routes inbound LCE commands to the owning LCE by destination ID, which lets tiles carry more than two caches (e.g. I$, D$, accelerator LCE) behind one network port.

## Interface

Parameters:
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `lce_id_width_p`, `cce_block_width_p` and header widths.
- `num_lce_p`, 2: number of LCE channels, 1..8.

Ports:
- `clk_i` in 1: single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `lce_id_base_i` in `lce_id_width_p`: LCE ID of channel 0; channel i owns `lce_id_base_i+i`.
- `lce_req_header_i` in `[num_lce_p][lce_req_header_width_lp]`: per-LCE request headers.
- `lce_req_data_i` in `[num_lce_p][cce_block_width_p]`: per-LCE request data.
- `lce_req_v_i` in `num_lce_p`: per-LCE request valid.
- `lce_req_ready_and_o` out `num_lce_p`: per-LCE request ready.
- `lce_req_header_o` out `lce_req_header_width_lp`: merged request header.
- `lce_req_data_o` out `cce_block_width_p`: merged request data.
- `lce_req_v_o` out 1: merged request valid.
- `lce_req_ready_and_i` in 1: merged request ready.
- `lce_cmd_header_i` in `lce_cmd_header_width_lp`: network command header.
- `lce_cmd_data_i` in `cce_block_width_p`: network command data.
- `lce_cmd_v_i` in 1: network command valid.
- `lce_cmd_yumi_o` out 1: network command consume.
- `lce_cmd_header_o` out `[num_lce_p][lce_cmd_header_width_lp]`: per-LCE command header; broadcast to all channels.
- `lce_cmd_data_o` out `[num_lce_p][cce_block_width_p]`: per-LCE command data; broadcast to all channels.
- `lce_cmd_v_o` out `num_lce_p`: per-LCE command valid; one-hot or zero.
- `lce_cmd_yumi_i` in `num_lce_p`: per-LCE command consume.
- `cmd_misroute_o` out 1: sticky; a command with an out-of-range destination was dropped.
- `req_count_o` out `[num_lce_p][32]`: per-channel accepted-request counters; see Configuration.

## Operation

Request path:
- The output register holds one request: `out_v_r`, header and data.
- The arbiter is round-robin with pointer `rr_r`. Priority is `rr_r`, then `rr_r+1`, and so on, modulo `num_lce_p`.
- `space = ~out_v_r | lce_req_ready_and_i`.
- `lce_req_ready_and_o[i] = space & grant[i]`. `grant` is one-hot over `lce_req_v_i`.
- Ready depends combinationally on the valid inputs. This dependence is permitted and must be documented at instantiation.
- On a handshake on channel i: the register loads channel i's header and data, `out_v_r` is set, and `rr_r` becomes `(i+1) mod num_lce_p`.
- With no handshake, `rr_r` holds.
- An output drain and a new load in the same cycle both happen; the register is overwritten and `out_v_r` stays 1.
- A drain with no load clears `out_v_r`.

Command path:
- The command path is combinational and unbuffered. `idx = dst_id - lce_id_base_i`, computed at `lce_id_width_p` width, unsigned.
- If `idx < num_lce_p`: `lce_cmd_v_o[idx] = lce_cmd_v_i` and `lce_cmd_yumi_o = lce_cmd_yumi_i[idx]`.
- Otherwise: all `lce_cmd_v_o` are 0, `lce_cmd_yumi_o = lce_cmd_v_i` (the command is dropped), and `cmd_misroute_o` is set on the cycle of the drop.
- `lce_cmd_yumi_i[j]` for j≠idx is ignored.

## Timing

- Reset values: `out_v_r` = 0, `rr_r` = 0, `cmd_misroute_o` = 0, all `req_count_o` = 0. `lce_req_ready_and_o` is 0 whenever no `lce_req_v_i` is asserted.
- Request latency: 1 cycle from input handshake to `lce_req_v_o`. Full throughput is one request per cycle when downstream is always ready.
- When the output register is full and stalled, all `lce_req_ready_and_o` are 0. Header and data on the output stay stable until the output handshake.
- Command latency: 0 cycles.
- Asserting `reset_i` mid-operation discards the buffered request. Upstream must not rely on its delivery.
- `cmd_misroute_o` clears only on reset.

## Configuration

`BP_LCE_MUX_STATS_EN`:
- Defined: each channel has a 32-bit counter that increments on that channel's request handshake and wraps from `0xFFFF_FFFF` to 0. The counters drive `req_count_o`.
- Undefined: no counter flops; `req_count_o` is tied to 0.

## Structure

- `bp_common_pkg` provides the bedrock header typedefs. The command `dst_id` field is extracted through the `bp_bedrock_lce_cmd_header_s` cast; there is no local field slicing.
- Add `lce_mux_max_lce_gp = 8` to `bp_common_pkg`.
- One sub-module: `bp_lce_mux_rr_arb`, the round-robin arbiter with `v_i`, `yumi_i` and `grant_o`; it owns `rr_r`.

## Test plan

- Reset, then all `lce_req_v_i` held at 1 with the output always ready: grants go 0,1,0,1,…. One output per cycle, and header data matches the granted channel.
- Output stalled 5 cycles with the register full: all `lce_req_ready_and_o` = 0. The output header stays stable, and exactly one request is accepted in the cycle the stall releases.
- `num_lce_p`=3, `lce_id_base_i`=4, commands with `dst_id` 4, 6, 5: `lce_cmd_v_o` = 001, 100, 010 in turn. `lce_cmd_yumi_o` tracks the selected `lce_cmd_yumi_i`.
- Command with `dst_id`=9 (base 4, N=3): consumed in the same cycle, no `lce_cmd_v_o`, and `cmd_misroute_o` goes to 1 and stays there.
- Assert `reset_i` for 1 cycle while `lce_req_v_o`=1: the next cycle `lce_req_v_o`=0, `rr_r`=0 and the counters are 0.
- With `BP_LCE_MUX_STATS_EN` defined, 7 requests on channel 1: `req_count_o[1]`=7 and the other channels read 0. Undefined: all counters read 0.
